prefetch_fetch_unit: RTL

PREFETCH_FETCH_UNIT -- requirements
Module: prefetch_fetch_unit

---
 rtl/prefetch_fetch_unit_pkg.sv | 20 ++
 rtl/Incrementer.sv | 11 +
 rtl/fetch_queue.sv | 41 ++++
 rtl/prefetch_fetch_unit.sv | 122 ++++++++++++
 4 files changed

// File: rtl/prefetch_fetch_unit_pkg.sv
// Shared constants and types for the instruction prefetch unit:
// memory access kinds, fetch FSM encoding and queue entry layout.
package prefetch_fetch_unit_pkg;

  localparam logic READ      = 1'b0;
  localparam logic WRITE     = 1'b1;
  localparam int   WORD_SIZE = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/Incrementer.sv
// Plain +1 incrementer; used on the word index of a fetch address.
module Incrementer #(
  parameter int WIDTH = 30
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] result
);

  assign result = value + WIDTH'(1);

endmodule

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {instruction, pc} pairs with single-cycle flush.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Instruction prefetcher: issues sequential word reads into a small queue,
// handling redirects that flush the queue and drop in-flight responses.
module prefetch_fetch_unit
  import prefetch_fetch_unit_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            memory_interface_enable,
  output logic            memory_interface_state,
  output logic [XLEN-1:0] memory_interface_address,
  output logic [3:0]      memory_interface_frame_mask,
  input  logic            memory_interface_ready,
  input  logic [XLEN-1:0] memory_interface_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AB = $clog2(WORD_SIZE);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] fetch_pc, fetch_pc_next;
  logic [XLEN-1:0] req_addr, req_addr_next;
  logic [XLEN-1:0] addr_plus4;
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-AB-1:0] inc_word;
  logic [CW-1:0]   count, count_after;
  logic            push, pop, ready_hit, room_now, room_after;
  fetch_entry_t    push_entry, head_entry;

  Incrementer #(.WIDTH(XLEN-AB)) u_inc (
    .value  (req_addr[XLEN-1:AB]),
    .result (inc_word)
  );

  assign addr_plus4   = {inc_word, AB'(0)};
  assign redirect_tgt = {redirect_pc[XLEN-1:AB], AB'(0)};

  assign ready_hit   = (state == REQUEST) && memory_interface_ready;
  assign push        = ready_hit && !redirect_valid;
  assign pop         = instr_valid && instr_ready && !redirect_valid;
  assign count_after = count + CW'(push) - CW'(pop);
  assign room_now    = count < CW'(DEPTH);
  assign room_after  = count_after < CW'(DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      req_addr <= req_addr_next;
    end
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_addr_next = req_addr;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_next = redirect_tgt;
        end else if (enable && room_now) begin
          state_next    = REQUEST;
          req_addr_next = fetch_pc;
        end
      end
      REQUEST: begin
        if (redirect_valid) begin
          fetch_pc_next = redirect_tgt;
          state_next    = memory_interface_ready ? IDLE : DISCARD;
        end else if (memory_interface_ready) begin
          fetch_pc_next = addr_plus4;
          // Chain the next request directly when the queue still has room.
          if (enable && room_after) req_addr_next = addr_plus4;
          else                      state_next    = IDLE;
        end
      end
      DISCARD: begin
        if (redirect_valid)         fetch_pc_next = redirect_tgt;
        if (memory_interface_ready) state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign push_entry.data = memory_interface_data;
  assign push_entry.pc   = req_addr;

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(2*XLEN)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (count)
  );

  assign memory_interface_enable     = (state != IDLE);
  assign memory_interface_state      = READ;
  assign memory_interface_address    = (state == IDLE) ? fetch_pc : req_addr;
  assign memory_interface_frame_mask = 4'b1111;

  assign instr_valid = (count != '0);
  assign instr_data  = head_entry.data;
  assign instr_pc    = head_entry.pc;

endmodule
